// File: rtl/dcf77_transmitter_pkg.sv
// Shared types for the DCF77 transmit path: frame word, FSM states, bit positions.
// Latency: none, declarations only.
// Backpressure: not applicable.
package dcf77_transmitter_pkg;

  // One transmitted minute: bits 0..58. Second 59 carries no pulse.
  typedef logic [58:0] dcf77_frame_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GAP  = 2'd1,
    SEND = 2'd2
  } tx_state_t;

  // BCD date/time of the minute to be sent. Each field is LSB-first on air.
  typedef struct packed {
    logic [7:0] year;    // 00..99
    logic [4:0] month;   // 01..12
    logic [5:0] day;     // 01..31
    logic [2:0] dow;     // 1..7, Monday = 1
    logic [5:0] hour;    // 00..23
    logic [6:0] minute;  // 00..59
  } date_time_t;

  localparam int BIT_CEST          = 17;
  localparam int BIT_CET           = 18;
  localparam int BIT_START_OF_TIME = 20;
  localparam int BIT_MINUTE        = 21;
  localparam int BIT_P1            = 28;
  localparam int BIT_HOUR          = 29;
  localparam int BIT_P2            = 35;
  localparam int BIT_DAY           = 36;
  localparam int BIT_DOW           = 42;
  localparam int BIT_MONTH         = 45;
  localparam int BIT_YEAR          = 50;
  localparam int BIT_P3            = 58;

  localparam logic [5:0] LAST_DATA_BIT = 6'd58;
  localparam logic [5:0] MINUTE_MARK   = 6'd59;

endpackage

// File: rtl/dcf77_frame_encode.sv
// Maps a BCD date/time plus the summer-time flag to a DCF77 minute frame.
// Latency: purely combinational.
// Backpressure: none; output follows the inputs continuously.
module dcf77_frame_encode
  import dcf77_transmitter_pkg::*;
(
  input  date_time_t   time_in,
  input  logic         cest,
  output dcf77_frame_t frame
);

  // Place every field at its fixed position; parities are even over each group.
  always_comb begin
    frame = '0;
    frame[BIT_CEST]              = cest;
    frame[BIT_CET]               = ~cest;
    frame[BIT_START_OF_TIME]     = 1'b1;
    frame[BIT_MINUTE +: 7]       = time_in.minute;
    frame[BIT_P1]                = ^time_in.minute;
    frame[BIT_HOUR +: 6]         = time_in.hour;
    frame[BIT_P2]                = ^time_in.hour;
    frame[BIT_DAY +: 6]          = time_in.day;
    frame[BIT_DOW +: 3]          = time_in.dow;
    frame[BIT_MONTH +: 5]        = time_in.month;
    frame[BIT_YEAR +: 8]         = time_in.year;
    frame[BIT_P3]                = ^{time_in.day, time_in.dow, time_in.month, time_in.year};
  end

endmodule

// File: rtl/dcf77_transmitter.sv
// DCF77 keying generator: sends minute frames built from time_in while enabled.
// Latency: first carrier reduction exactly TICKS_PER_SECOND strobes after the strobe that accepts start.
// Backpressure: none; runs free on clk_en, start outside IDLE is ignored.
module dcf77_transmitter
  import dcf77_transmitter_pkg::*;
#(
  parameter int TICKS_PER_SECOND = 100,
  parameter int PULSE_ZERO       = 10,
  parameter int PULSE_ONE        = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk_en,
  input  logic       enable,
  input  logic       start,
  input  logic       cest,
  input  date_time_t time_in,
  output logic       dcf77_tx,
  output logic [5:0] bit_index,
  output logic       frame_start,
  output logic       busy
);

  localparam int SLOT_W = $clog2(TICKS_PER_SECOND);
  localparam int CMP_W  = SLOT_W + 1;
  localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(TICKS_PER_SECOND - 1);
  localparam logic [CMP_W-1:0]  WIDTH_ZERO = CMP_W'(PULSE_ZERO);
  localparam logic [CMP_W-1:0]  WIDTH_ONE  = CMP_W'(PULSE_ONE);

  tx_state_t         state_q;
  logic [SLOT_W-1:0] slot_q;
  logic [5:0]        bit_index_q;
  dcf77_frame_t      frame_q;
  logic              start_q;
  logic              tx_q;
  logic              frame_start_q;
  logic              busy_q;

  dcf77_frame_t      frame_d;
  logic [SLOT_W-1:0] slot_d;
  logic [5:0]        bit_index_d;
  logic [63:0]       frame_ext;
  logic [CMP_W-1:0]  width_cur;

  dcf77_frame_encode u_encode (
    .time_in (time_in),
    .cest    (cest),
    .frame   (frame_d)
  );

  // Next slot/bit values and the pulse width of the bit currently on air.
  always_comb begin
    slot_d      = slot_q + 1'b1;
    bit_index_d = bit_index_q + 6'd1;
    frame_ext   = {5'b0, frame_q};
    width_cur   = frame_ext[bit_index_q] ? WIDTH_ONE : WIDTH_ZERO;
  end

  // Transmit FSM: slot and bit counters, frame capture and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      slot_q        <= '0;
      bit_index_q   <= MINUTE_MARK;
      frame_q       <= '0;
      start_q       <= 1'b0;
      tx_q          <= 1'b0;
      frame_start_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      frame_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (clk_en && (start_q || start)) begin
            state_q     <= GAP;
            start_q     <= 1'b0;
            busy_q      <= 1'b1;
            slot_q      <= '0;
            bit_index_q <= MINUTE_MARK;
          end else if (start) begin
            start_q <= 1'b1;
          end
        end
        GAP: begin
          if (clk_en) begin
            if (slot_q == SLOT_LAST) begin
              // Minute mark over: capture the frame and begin bit 0.
              state_q       <= SEND;
              frame_q       <= frame_d;
              slot_q        <= '0;
              bit_index_q   <= 6'd0;
              tx_q          <= 1'b1;
              frame_start_q <= 1'b1;
            end else begin
              slot_q <= slot_d;
            end
          end
        end
        SEND: begin
          if (clk_en) begin
            if (slot_q == SLOT_LAST) begin
              slot_q <= '0;
              if (bit_index_q == LAST_DATA_BIT) begin
                tx_q        <= 1'b0;
                bit_index_q <= MINUTE_MARK;
                if (enable) begin
                  state_q <= GAP;
                end else begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                end
              end else begin
                bit_index_q <= bit_index_d;
                tx_q        <= 1'b1;
              end
            end else begin
              slot_q <= slot_d;
              tx_q   <= ({1'b0, slot_d} < width_cur);
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign dcf77_tx    = tx_q;
  assign bit_index   = bit_index_q;
  assign frame_start = frame_start_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_dcf77_transmitter.sv
// Bench for dcf77_transmitter: frame content, pulse widths, sequencing, reset.
// Latency: one clk_en strobe every second clk cycle.
// Backpressure: not applicable.
module tb_dcf77_transmitter;
  import dcf77_transmitter_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       clk_en = 1'b0;
  logic       enable = 1'b0;
  logic       start = 1'b0;
  logic       cest = 1'b0;
  date_time_t time_in = '0;
  logic       dcf77_tx;
  logic [5:0] bit_index;
  logic       frame_start;
  logic       busy;

  int checks = 0;
  int failures = 0;

  int hc[64];
  int strobe_no = 0;
  int fs_cnt = 0;
  int last_fs = -1;
  int period = 0;
  int fs0 = 0;
  logic [58:0] fr[1:3];

  typedef struct {
    int         frm;
    int         lo;
    int         n;
    logic [7:0] exp;
  } spot_t;
  spot_t spots[$];

  always #5 clk = ~clk;

  dcf77_transmitter dut (
    .clk         (clk),
    .reset       (reset),
    .clk_en      (clk_en),
    .enable      (enable),
    .start       (start),
    .cest        (cest),
    .time_in     (time_in),
    .dcf77_tx    (dcf77_tx),
    .bit_index   (bit_index),
    .frame_start (frame_start),
    .busy        (busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clk_en strobe, then tally what the DUT shows after that edge.
  task automatic strobe();
    @(negedge clk) clk_en = 1'b1;
    @(negedge clk) clk_en = 1'b0;
    strobe_no++;
    if (dcf77_tx === 1'b1) hc[bit_index]++;
    if (frame_start === 1'b1) begin
      fs_cnt++;
      if (last_fs >= 0) period = strobe_no - last_fs;
      last_fs = strobe_no;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) strobe();
  endtask

  task automatic clear_hc();
    for (int i = 0; i < 64; i++) hc[i] = 0;
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic set_time(input logic [7:0] y, input logic [4:0] mo, input logic [5:0] d,
                          input logic [2:0] dw, input logic [5:0] h, input logic [6:0] mi,
                          input logic c);
    time_in.year   = y;
    time_in.month  = mo;
    time_in.day    = d;
    time_in.dow    = dw;
    time_in.hour   = h;
    time_in.minute = mi;
    cest           = c;
  endtask

  function automatic logic [58:0] decode();
    logic [58:0] d;
    for (int b = 0; b < 59; b++) begin
      if (hc[b] == 20) d[b] = 1'b1;
      else if (hc[b] == 10) d[b] = 1'b0;
      else d[b] = 1'bx;
    end
    return d;
  endfunction

  function automatic int bad_widths();
    int n = 0;
    for (int b = 0; b < 59; b++) if (hc[b] != 10 && hc[b] != 20) n++;
    return n;
  endfunction

  function automatic int hc_sum();
    int s = 0;
    for (int b = 0; b < 64; b++) s += hc[b];
    return s;
  endfunction

  initial begin
    logic [7:0] a;

    // Hand-decoded expected bit groups, LSB = lowest bit number.
    spots.push_back('{1, 0, 8, 8'h00});   // bits 0..7
    spots.push_back('{1, 8, 8, 8'h00});   // bits 8..15
    spots.push_back('{1, 17, 4, 8'h0A});  // 17=0 18=1 19=0 20=1
    spots.push_back('{1, 21, 8, 8'h59});  // minute 59, P1=0
    spots.push_back('{1, 29, 7, 8'h63});  // hour 23, P2=1
    spots.push_back('{1, 36, 8, 8'h29});  // day 29, dow bits 42,43
    spots.push_back('{1, 44, 1, 8'h01});  // dow bit 44 (dow 4)
    spots.push_back('{1, 45, 5, 8'h02});  // month 02
    spots.push_back('{1, 50, 8, 8'h24});  // year 24
    spots.push_back('{1, 58, 1, 8'h01});  // P3
    spots.push_back('{2, 17, 4, 8'h09});  // 17=1 18=0 19=0 20=1
    spots.push_back('{2, 21, 8, 8'h00});  // minute 00, P1=0
    spots.push_back('{2, 29, 7, 8'h00});  // hour 00, P2=0
    spots.push_back('{2, 36, 8, 8'h71});  // day 31, dow bits
    spots.push_back('{2, 45, 5, 8'h12});  // month 12
    spots.push_back('{2, 50, 8, 8'h99});  // year 99
    spots.push_back('{2, 58, 1, 8'h01});  // P3
    spots.push_back('{3, 21, 8, 8'h59});
    spots.push_back('{3, 29, 7, 8'h63});
    spots.push_back('{3, 50, 8, 8'h24});

    clear_hc();
    set_time(8'h24, 5'h02, 6'h29, 3'd4, 6'h23, 7'h59, 1'b0);
    enable = 1'b1;

    // Reset values while reset is held.
    repeat (3) @(negedge clk);
    chk("rst_tx", 64'(dcf77_tx), 64'd0);
    chk("rst_bit_index", 64'(bit_index), 64'd59);
    chk("rst_frame_start", 64'(frame_start), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    @(negedge clk) reset = 1'b1;
    run(3);
    chk("idle_busy", 64'(busy), 64'd0);

    // Frame 1: 100 silent strobes of minute mark, then bit 0.
    pulse_start();
    run(100);
    chk("gap_pulses", 64'(hc_sum()), 64'd0);
    chk("gap_frame_start", 64'(fs_cnt), 64'd0);
    chk("gap_bit_index", 64'(bit_index), 64'd59);
    chk("gap_busy", 64'(busy), 64'd1);
    clear_hc();
    run(1);
    chk("f1_frame_start", 64'(frame_start), 64'd1);
    chk("f1_bit0_index", 64'(bit_index), 64'd0);
    chk("f1_bit0_tx", 64'(dcf77_tx), 64'd1);
    run(999);
    // New time mid-frame must only show up in the next frame.
    set_time(8'h99, 5'h12, 6'h31, 3'd5, 6'h00, 7'h00, 1'b1);
    pulse_start();
    run(5000);
    fr[1] = decode();
    chk("f1_widths_bad", 64'(bad_widths()), 64'd0);
    chk("f1_bit59_pulses", 64'(hc[59]), 64'd0);
    chk("f1_fs_count", 64'(fs_cnt), 64'd1);

    // Frame 2: period check, enable dropped at bit 30, stray start.
    clear_hc();
    run(1);
    chk("f2_frame_start", 64'(frame_start), 64'd1);
    chk("frame_period", 64'(period), 64'd6000);
    run(3049);
    chk("f2_mid_bit_index", 64'(bit_index), 64'd30);
    enable = 1'b0;
    pulse_start();
    run(2850);
    chk("f2_end_busy", 64'(busy), 64'd1);
    chk("f2_end_bit_index", 64'(bit_index), 64'd58);
    fr[2] = decode();
    chk("f2_widths_bad", 64'(bad_widths()), 64'd0);
    run(1);
    chk("f2_idle_busy", 64'(busy), 64'd0);
    chk("f2_idle_bit_index", 64'(bit_index), 64'd59);
    chk("f2_idle_tx", 64'(dcf77_tx), 64'd0);
    clear_hc();
    fs0 = fs_cnt;
    run(300);
    chk("post_idle_pulses", 64'(hc_sum()), 64'd0);
    chk("post_idle_fs", 64'(fs_cnt), 64'(fs0));
    chk("post_idle_busy", 64'(busy), 64'd0);

    // Frame 3: start with enable low still sends exactly one frame.
    set_time(8'h24, 5'h02, 6'h29, 3'd4, 6'h23, 7'h59, 1'b0);
    pulse_start();
    run(100);
    chk("f3_gap_busy", 64'(busy), 64'd1);
    chk("f3_gap_pulses", 64'(hc_sum()), 64'd0);
    clear_hc();
    run(5900);
    fr[3] = decode();
    chk("f3_widths_bad", 64'(bad_widths()), 64'd0);
    chk("f3_fs_count", 64'(fs_cnt), 64'(fs0 + 1));
    run(1);
    chk("f3_idle_busy", 64'(busy), 64'd0);
    chk("f3_idle_bit_index", 64'(bit_index), 64'd59);

    // Bit-group checks from the table.
    foreach (spots[i]) begin
      a = '0;
      for (int k = 0; k < spots[i].n; k++) a[k] = fr[spots[i].frm][spots[i].lo + k];
      checks++;
      if (a !== spots[i].exp) begin
        failures++;
        $display("FAIL spot frame%0d bit%0d: got %0h expected %0h",
                 spots[i].frm, spots[i].lo, a, spots[i].exp);
      end
    end

    // Asynchronous reset while the carrier is reduced.
    pulse_start();
    run(101);
    chk("pre_rst_tx", 64'(dcf77_tx), 64'd1);
    #1 reset = 1'b0;
    #1;
    chk("async_rst_tx", 64'(dcf77_tx), 64'd0);
    chk("async_rst_bit_index", 64'(bit_index), 64'd59);
    chk("async_rst_busy", 64'(busy), 64'd0);
    chk("async_rst_frame_start", 64'(frame_start), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    clear_hc();
    run(150);
    chk("after_rst_pulses", 64'(hc_sum()), 64'd0);
    chk("after_rst_busy", 64'(busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
